// File: rtl/fir_feeder.sv
// fir_feeder: FIFO-buffered sample feeder that strobes one sample into a folded FIR every PERIOD cycles.
//   clk     - rising-edge clock
//   rst     - asynchronous active-low reset
//   s_valid - upstream sample valid; s_data - upstream sample; s_ready - a sample can be taken this cycle
//   flush   - synchronous discard of queued samples and of the period in progress
//   en      - one-cycle strobe to the filter; din - sample presented to the filter
//   busy    - a filter period is in progress; level - FIFO occupancy
module fir_feeder #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 29,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic signed [WIDTH-1:0]  s_data,
    output logic                     s_ready,
    input  logic                     flush,
    output logic                     en,
    output logic signed [WIDTH-1:0]  din,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               wcnt_q, wcnt_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     en_q, en_d;
    logic signed [WIDTH-1:0]  din_q, din_d;
    logic signed [WIDTH-1:0]  mem_q [DEPTH];
    logic                     push, pop;

    assign s_ready = level_q < LW'(DEPTH);
    assign push    = s_valid && s_ready && !flush;
    assign pop     = state_q == IDLE && level_q != '0 && !flush;
    assign en      = en_q;
    assign din     = din_q;
    assign busy    = state_q == WAIT;
    assign level   = level_q;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        en_d     = 1'b0;
        din_d    = din_q;
        if (flush) begin
            state_d  = IDLE;
            wcnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            level_d  = level_q + LW'(push) - LW'(pop);
            if (pop) begin
                en_d    = 1'b1;
                din_d   = mem_q[rd_ptr_q];
                wcnt_d  = 8'(PERIOD - 1);
                state_d = WAIT;
            end else if (state_q == WAIT) begin
                wcnt_d  = wcnt_q - 8'd1;
                state_d = wcnt_q == 8'd1 ? IDLE : WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            en_q     <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            en_q     <= en_d;
            din_q    <= din_d;
        end
    end

    // Storage is never read before being written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end
endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: randomized and directed checks of fir_feeder against a queue-based reference model.
module tb_fir_feeder;
    localparam int PERIOD = 29;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        flush = 1'b0;
    logic        en;
    logic [15:0] din;
    logic        busy;
    logic [2:0]  level;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [15:0] mq[$];
    int          since = PERIOD;
    logic [15:0] m_din = '0;
    logic        m_en = 1'b0;

    fir_feeder #(.WIDTH(16), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .flush(flush), .en(en), .din(din), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".en"}, 32'(en), 32'(m_en));
        chk({tag, ".din"}, 32'(din), 32'(m_din));
        chk({tag, ".busy"}, 32'(busy), 32'(since < PERIOD));
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(mq.size() < DEPTH));
    endtask

    // Model: pops happen whenever data is queued and at least PERIOD edges have passed since the last pop.
    task automatic step(input logic v, input logic [15:0] d, input logic f, input string tag);
        bit do_pop, do_push;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        flush   = f;
        chk({tag, ".ready_pre"}, 32'(s_ready), 32'(mq.size() < DEPTH));
        @(posedge clk);
        if (f) begin
            mq.delete();
            since = PERIOD;
            m_en  = 1'b0;
        end else begin
            do_pop  = since >= PERIOD && mq.size() > 0;
            do_push = v && mq.size() < DEPTH;
            if (do_pop) begin
                m_din = mq.pop_front();
                m_en  = 1'b1;
                since = 1;
            end else begin
                m_en = 1'b0;
                if (since < PERIOD) since++;
            end
            if (do_push) mq.push_back(d);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, tag);
    endtask

    initial begin
        #1;
        check_outputs("reset");
        #20;
        @(negedge clk);
        rst = 1'b1;
        idle(2, "post_reset");

        step(1'b1, 16'h1234, 1'b0, "single");
        idle(35, "single");

        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, "burst");
        idle(6 * PERIOD + 5, "burst");

        step(1'b1, 16'hAAAA, 1'b0, "starve");
        idle(40, "starve");
        step(1'b1, 16'h5555, 1'b0, "starve");
        idle(35, "starve");

        for (int i = 0; i < 3; i++) step(1'b1, 16'h0F00 + 16'(i), 1'b0, "flush");
        idle(5, "flush");
        step(1'b0, 16'h0, 1'b1, "flush");
        idle(70, "flush");

        for (int i = 0; i < 3; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0, "areset");
        idle(4, "areset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        mq.delete();
        since = PERIOD;
        m_en  = 1'b0;
        m_din = '0;
        check_outputs("areset_now");
        @(negedge clk);
        rst = 1'b1;
        idle(40, "areset_after");

        for (int i = 0; i < 20; i++) begin
            int gap = int'($urandom_range(0, 40));
            for (int g = 0; g < gap; g++) step(1'b0, 16'($urandom), 1'b0, "wrap");
            step(1'b1, 16'($urandom), 1'b0, "wrap");
        end
        idle(5 * PERIOD, "wrap");
        for (int i = 0; i < 150; i++) step(1'b1, 16'($urandom), 1'b0, "full_hold");

        for (int i = 0; i < 2000; i++) begin
            int dens = (i / 200) % 4;
            logic v = $urandom_range(0, 7) < dens * 2 + 1;
            logic f = $urandom_range(0, 99) == 0;
            step(v, 16'($urandom), f, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
